// File: rtl/sc_run_ctrl_pkg.sv
// Shared definitions for the single-cycle CPU run controller, the CPU and the sim top.
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } run_state_t;

    localparam logic [5:0]  HALT_OPCODE = 6'h3F;
    localparam int unsigned MEMORY_BITS = 12;
    localparam logic [31:0] MAX_CYCLES  = 32'd100_000_000;

endpackage

// File: rtl/sc_run_ctrl_sat_counter32.sv
// 32-bit cycle counter with synchronous clear, count enable and saturation at all-ones.
module sat_counter32 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    // Clear wins over enable; the count holds once it reaches all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en && (r_q != '1)) begin
            r_q <= r_q + 32'd1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sc_run_ctrl.sv
// Run controller for SC_CPU: loads the program image, releases the CPU, counts
// cycles and stops on a halt opcode or when the cycle budget runs out.
// Optional: SC_RUN_CTRL_SELFLOOP_EN also treats a PC held for 2 RUN cycles as a halt.
module sc_run_ctrl #(
    parameter int unsigned MEMORY_BITS = sc_pkg::MEMORY_BITS,
    parameter logic [31:0] MAX_CYCLES  = sc_pkg::MAX_CYCLES,
    parameter logic [5:0]  HALT_OPCODE = sc_pkg::HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [MEMORY_BITS-1:0] load_addr,
    input  logic [31:0]            load_data,
    input  logic                   load_last,
    output logic                   im_we,
    output logic [MEMORY_BITS-1:0] im_waddr,
    output logic [31:0]            im_wdata,
    output logic                   cpu_rst,
    output logic                   cpu_clk_en,
    input  logic [31:0]            pc,
    input  logic [31:0]            instr,
    output logic [31:0]            cycles_consumed,
    output logic                   done,
    output logic                   timeout,
    output logic [1:0]             state
);

    import sc_pkg::*;

    run_state_t             r_state;
    run_state_t             w_next;
    logic                   r_im_we;
    logic [MEMORY_BITS-1:0] r_im_waddr;
    logic [31:0]            r_im_wdata;
    logic                   r_cpu_rst;
    logic                   r_cpu_clk_en;
    logic                   r_done;
    logic                   r_timeout;
    logic                   w_accept;
    logic                   w_enter_load;
    logic                   w_running;
    logic                   w_selfloop;
    logic                   w_halt;
    logic                   w_budget;
    logic                   w_run_halt;
    logic                   w_run_timeout;
    logic [31:0]            w_count;

    assign load_ready   = (r_state == ST_LOAD);
    assign w_accept     = load_valid && load_ready;
    assign w_enter_load = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_running    = (r_state == ST_RUN);
    assign w_budget     = (w_count == (MAX_CYCLES - 32'd1));

`ifdef SC_RUN_CTRL_SELFLOOP_EN
    logic [31:0] r_prev_pc;
    logic        r_prev_run;
    logic        w_unused_instr;

    // Remember last cycle's PC so a jump-to-self is seen on its second RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_pc  <= '0;
            r_prev_run <= 1'b0;
        end else begin
            r_prev_pc  <= pc;
            r_prev_run <= w_running;
        end
    end

    assign w_selfloop     = r_prev_run && (pc == r_prev_pc);
    assign w_unused_instr = ^instr[25:0];
`else
    logic w_unused_inputs;

    assign w_selfloop      = 1'b0;
    assign w_unused_inputs = ^{pc, instr[25:0]};
`endif

    assign w_halt = (instr[31:26] == HALT_OPCODE) || w_selfloop;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; a halt outranks the budget expiring in the same cycle.
    always_comb begin
        w_next        = r_state;
        w_run_halt    = 1'b0;
        w_run_timeout = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_LOAD;
            ST_LOAD: if (w_accept && load_last) w_next = ST_RUN;
            ST_RUN: begin
                if (w_halt) begin
                    w_next     = ST_HALT;
                    w_run_halt = 1'b1;
                end else if (w_budget) begin
                    w_next        = ST_HALT;
                    w_run_timeout = 1'b1;
                end
            end
            ST_HALT: if (start) w_next = ST_LOAD;
            default: w_next = ST_IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_im_we      <= 1'b0;
            r_im_waddr   <= '0;
            r_im_wdata   <= '0;
            r_cpu_rst    <= 1'b0;
            r_cpu_clk_en <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_im_we      <= w_accept;
            if (w_accept) begin
                r_im_waddr <= load_addr;
                r_im_wdata <= load_data;
            end
            r_cpu_rst    <= (w_next == ST_RUN) || (w_next == ST_HALT);
            r_cpu_clk_en <= (w_next == ST_RUN);
            if (w_enter_load) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_run_halt) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_run_timeout) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    sat_counter32 u_cycle_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_enter_load),
        .i_en    (w_running),
        .o_q     (w_count)
    );

    assign im_we           = r_im_we;
    assign im_waddr        = r_im_waddr;
    assign im_wdata        = r_im_wdata;
    assign cpu_rst         = r_cpu_rst;
    assign cpu_clk_en      = r_cpu_clk_en;
    assign cycles_consumed = w_count;
    assign done            = r_done;
    assign timeout         = r_timeout;
    assign state           = r_state;

endmodule

// File: tb/tb_sc_run_ctrl.sv
// Scoreboard bench for sc_run_ctrl with a small behavioural CPU that fetches from
// the bench's copy of the program image.
module tb_sc_run_ctrl;

    localparam int unsigned BUDGET  = 16;
    localparam logic [5:0]  OP_HALT = 6'h3F;
    localparam logic [5:0]  OP_JSELF = 6'h02;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [11:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        im_we;
    logic [11:0] im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic        cpu_clk_en;
    logic [31:0] pc = '0;
    logic [31:0] instr;
    logic [31:0] cycles_consumed;
    logic        done;
    logic        timeout;
    logic [1:0]  state;

    logic [31:0] prog [64];
    assign instr = prog[pc[7:2]];

    typedef struct { logic [11:0] a; logic [31:0] d; bit last; } wr_t;
    typedef struct { int unsigned cyc; bit to; } end_t;
    wr_t  wq[$];
    end_t eq[$];

    int tests = 0;
    int fails = 0;
    int ends_seen = 0;
    int ends_exp = 0;

    sc_run_ctrl #(
        .MEMORY_BITS (12),
        .MAX_CYCLES  (32'd16),
        .HALT_OPCODE (6'h3F)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_last       (load_last),
        .im_we           (im_we),
        .im_waddr        (im_waddr),
        .im_wdata        (im_wdata),
        .cpu_rst         (cpu_rst),
        .cpu_clk_en      (cpu_clk_en),
        .pc              (pc),
        .instr           (instr),
        .cycles_consumed (cycles_consumed),
        .done            (done),
        .timeout         (timeout),
        .state           (state)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk_reset_values(input string tag);
        chk({tag, "_load_ready"}, {31'd0, load_ready}, 0);
        chk({tag, "_im_we"}, {31'd0, im_we}, 0);
        chk({tag, "_im_waddr"}, {20'd0, im_waddr}, 0);
        chk({tag, "_im_wdata"}, im_wdata, 0);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 0);
        chk({tag, "_cpu_clk_en"}, {31'd0, cpu_clk_en}, 0);
        chk({tag, "_cycles"}, cycles_consumed, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 0);
        chk({tag, "_state"}, {30'd0, state}, 0);
    endfunction

    // Reference: walk the program word by word as the CPU would, one run cycle each.
    function automatic end_t model_run();
        end_t r;
        int unsigned idx = 0;
        int unsigned prev = 999;
        logic [31:0] w;
        r.cyc = BUDGET;
        r.to  = 1'b1;
        for (int unsigned k = 1; k <= BUDGET; k++) begin
            w = prog[idx];
            if (w[31:26] == OP_HALT) begin
                r.cyc = k; r.to = 1'b0; return r;
            end
`ifdef SC_RUN_CTRL_SELFLOOP_EN
            if (k > 1 && idx == prev) begin
                r.cyc = k; r.to = 1'b0; return r;
            end
`endif
            prev = idx;
            if (w[31:26] != OP_JSELF) idx = idx + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        while (w[31:26] == OP_HALT || w[31:26] == OP_JSELF) w = $urandom;
        return w;
    endfunction

    function automatic void fill_prog(input int n);
        for (int i = 0; i < 64; i++) prog[i] = (i < n) ? plain_word() : 32'd0;
    endfunction

    // Behavioural CPU: PC resets while cpu_rst is low, advances on enabled cycles,
    // and stays put on a jump-to-self word.
    initial begin : cpu_model
        bit en_s;
        forever begin
            @(negedge clk);
            en_s = cpu_clk_en && cpu_rst;
            @(posedge clk);
            #1;
            if (!cpu_rst) pc = '0;
            else if (en_s && instr[31:26] != OP_JSELF) pc = pc + 32'd4;
        end
    end

    // Monitor: pops expected writes and run results as the DUT presents them.
    initial begin : monitor
        bit   prev_done = 1'b0;
        wr_t  w;
        end_t e;
        forever begin
            @(negedge clk);
            if (im_we) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h with no write expected", im_waddr);
                end else begin
                    w = wq.pop_front();
                    chk("im_waddr", {20'd0, im_waddr}, {20'd0, w.a});
                    chk("im_wdata", im_wdata, w.d);
                    chk("cpu_rst_at_write", {31'd0, cpu_rst}, {31'd0, w.last});
                    chk("cpu_clk_en_at_write", {31'd0, cpu_clk_en}, {31'd0, w.last});
                end
            end
            if (done && !prev_done) begin
                ends_seen++;
                if (eq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done with no run outstanding");
                end else begin
                    e = eq.pop_front();
                    chk("cycles_consumed", cycles_consumed, e.cyc);
                    chk("timeout", {31'd0, timeout}, {31'd0, e.to});
                    chk("cpu_clk_en_after_end", {31'd0, cpu_clk_en}, 0);
                    chk("cpu_rst_after_end", {31'd0, cpu_rst}, 1);
                    chk("state_after_end", {30'd0, state}, 3);
                end
            end
            prev_done = done;
        end
    end

    task automatic load_image(input int n, input int gap_pct, input bit poke_start);
        wr_t w;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("load_ready_after_start", {31'd0, load_ready}, 1);
        chk("state_load", {30'd0, state}, 1);
        chk("cycles_cleared", cycles_consumed, 0);
        chk("done_cleared", {31'd0, done}, 0);
        chk("timeout_cleared", {31'd0, timeout}, 0);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
            end
            chk("load_ready_held", {31'd0, load_ready}, 1);
            load_valid = 1'b1;
            load_addr  = 12'(i);
            load_data  = prog[i];
            load_last  = (i == n - 1);
            start      = poke_start && ($urandom_range(1) == 1);
            w.a = 12'(i); w.d = prog[i]; w.last = (i == n - 1);
            wq.push_back(w);
            @(posedge clk); #1;
            load_valid = 1'b0;
            load_last  = 1'b0;
            start      = 1'b0;
        end
        eq.push_back(model_run());
        ends_exp++;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < int'(BUDGET) + 10; c++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL wait_done: got no done within %0d cycles", BUDGET + 10);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish by time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : main
        int n;
        int hidx;
        int kind;
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;

        #2 chk_reset_values("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Three-beat image, no halt: runs to the budget.
        fill_prog(3);
        load_image(3, 0, 1'b0);
        wait_done();

        // Halt fetched on the 5th run cycle.
        fill_prog(8);
        prog[4] = {OP_HALT, 26'h0001234};
        load_image(8, 30, 1'b0);
        wait_done();

        // Halt on the budget's last cycle.
        fill_prog(16);
        prog[15] = {OP_HALT, 26'h0};
        load_image(16, 0, 1'b0);
        wait_done();

        // Jump-to-self at PC 0x20.
        fill_prog(10);
        prog[8] = {OP_JSELF, 26'h0000008};
        load_image(10, 0, 1'b0);
        wait_done();

        // Reset during run cycle 7.
        fill_prog(4);
        load_image(4, 0, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        chk("cycles_before_reset", cycles_consumed, 6);
        rst = 1'b0;
        #1 chk_reset_values("midrun");
        eq.delete();
        ends_exp--;
        @(posedge clk); #1 rst = 1'b1;
        fill_prog(6);
        prog[2] = {OP_HALT, 26'h0};
        load_image(6, 20, 1'b0);
        wait_done();

        // Randomized images.
        for (int r = 0; r < 14; r++) begin
            n = $urandom_range(18, 1);
            fill_prog(n);
            kind = $urandom_range(3);
            if (kind == 0) begin
                hidx = $urandom_range(19);
                if (hidx >= n) begin
                    for (int i = n; i <= hidx; i++) prog[i] = plain_word();
                    n = hidx + 1;
                end
                prog[hidx] = {OP_HALT, 26'($urandom)};
            end else if (kind == 1) begin
                hidx = $urandom_range(17);
                if (hidx >= n) begin
                    for (int i = n; i <= hidx; i++) prog[i] = plain_word();
                    n = hidx + 1;
                end
                prog[hidx] = {OP_JSELF, 26'($urandom)};
            end
            load_image(n, 25, 1'b1);
            wait_done();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("write_queue_drained", wq.size(), 0);
        chk("end_queue_drained", eq.size(), 0);
        chk("runs_ended", ends_seen, ends_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_run_ctrl.md
# sc_run_ctrl

Run controller for the single-cycle CPU (`SC_CPU`). It loads a program image into instruction memory over a valid/ready port, then releases the CPU from reset and gates its clock enable while counting consumed cycles. It stops the CPU on a halt instruction or a cycle-budget timeout. It sits between the simulation/host harness and `SC_CPU`, replacing fixed-delay reset and `MAX_CLOCKS` sequencing.

## Interface
- `MEMORY_BITS`, 12: instruction-memory address width in words.
- `MAX_CYCLES`, 100000000: cycle budget; reaching it forces a timeout.
- `HALT_OPCODE`, 6'h3F: opcode in `instr[31:26]` that ends a run.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (the polarity and synchronicity are fixed).
- `start` in 1: one-cycle pulse that begins loading; it is accepted in IDLE or HALT only.
- `load_valid` in 1: the load beat is valid.
- `load_ready` out 1: the controller accepts a load beat.
- `load_addr` in MEMORY_BITS: word address of the beat.
- `load_data` in 32: instruction word.
- `load_last` in 1: marks the final beat of the image.
- `im_we` out 1: instruction-memory write enable.
- `im_waddr` out MEMORY_BITS: registered write address.
- `im_wdata` out 32: registered write data.
- `cpu_rst` out 1: active-low reset to `SC_CPU`.
- `cpu_clk_en` out 1: CPU advance enable (drives the `clkout` gate).
- `pc` in 32: current CPU PC.
- `instr` in 32: instruction currently fetched at `pc`.
- `cycles_consumed` out 32: CPU cycles run.
- `done` out 1: level signal; the run ended.
- `timeout` out 1: level signal; the run ended by budget.
- `state` out 2: encoding IDLE=0, LOAD=1, RUN=2, HALT=3.

## Operation
- IDLE: `load_ready`=0 and `cpu_rst`=0.
  - `start` moves to LOAD.
  - Entering LOAD clears `cycles_consumed`, `done` and `timeout`.
- LOAD: `load_ready`=1.
  - A beat transfers when `load_valid`&&`load_ready`.
  - The next cycle it appears as `im_we`=1 with `im_waddr`/`im_wdata`.
  - A beat with `load_last` moves to RUN.
  - `start` is ignored while in LOAD.
- RUN: `cpu_rst`=1 and `cpu_clk_en`=1.
  - `cycles_consumed` increments once per RUN cycle.
  - When `instr[31:26]`==`HALT_OPCODE`, go to HALT. That cycle is counted. `cpu_clk_en` is 0 from the next cycle.
  - When `cycles_consumed`==`MAX_CYCLES`-1 and the CPU has not halted, go to HALT with `timeout`=1.
  - If halt and timeout fire in the same cycle, halt wins and `timeout`=0.
- HALT: `cpu_clk_en`=0 and `cpu_rst` stays 1, so architectural state is inspectable. `done`=1.
  - `cycles_consumed` is frozen.
  - `start` re-enters LOAD.
- Counter width: 32 bits, saturating at 32'hFFFFFFFF. `MAX_CYCLES` must be ≤ 2^32−1.
- Reset mid-run: everything returns immediately to IDLE values. Memory contents are untouched.

## Timing
- Reset values:
  - `state`=IDLE
  - `load_ready`=0, `im_we`=0, `im_waddr`=0, `im_wdata`=0
  - `cpu_rst`=0, `cpu_clk_en`=0
  - `cycles_consumed`=0, `done`=0, `timeout`=0
- All outputs are registered except `load_ready`, which is decoded from `state`.
- `start` to first `load_ready`=1: 1 cycle.
- Accepted beat to `im_we`: 1 cycle.
- Last beat accepted at cycle N:
  - Memory write at N+1.
  - `cpu_rst`=1 and `cpu_clk_en`=1 at N+1. The final write lands at the CPU's first fetch edge; the CPU never fetches that address before cycle N+2.
- A halt fetched at cycle H gives `done`=1 and `cpu_clk_en`=0 at H+1.
- Back-to-back beats at one per cycle are supported. `load_ready` never drops inside LOAD.

## Configuration
- `SC_RUN_CTRL_SELFLOOP_EN`:
  - Defined: `pc` unchanged for 2 consecutive RUN cycles (a jump-to-self) is also treated as a halt, with the same latency and `timeout`=0.
  - Undefined: only `HALT_OPCODE` or the budget ends a run. A self-loop runs to timeout.

## Structure
- Shared package `sc_pkg` holds:
  - the state encoding constants;
  - `HALT_OPCODE`;
  - `MEMORY_BITS` and `MAX_CYCLES` defaults, shared with the CPU and the sim top.
- One sub-module, `sat_counter32`: saturating cycle counter with clear and enable.

## Test plan
- Reset, then `start`, then 3 beats at addresses 0,1,2 (last on 2) -> `im_we` at 3 consecutive cycles with matching addr/data; RUN begins the cycle after the third beat.
- Program with `instr` opcode 6'h3F at the 5th run cycle -> `cycles_consumed`=5, `done`=1, `timeout`=0, `cpu_clk_en`=0 next cycle.
- `MAX_CYCLES`=16, no halt -> after 16 RUN cycles `done`=1, `timeout`=1, `cycles_consumed`=16.
- `rst` pulsed low mid-RUN at cycle 7 -> all outputs at reset values immediately; a later `start` with a new load restarts with counter 0.
- Halt opcode on the budget's last cycle -> `timeout`=0, `done`=1.
- With `SC_RUN_CTRL_SELFLOOP_EN`, `pc` held at 0x20 for 2 cycles -> `done`=1, `timeout`=0. Without the macro -> timeout.
